// File: rtl/irq_controller.sv
// irq_controller: memory-mapped interrupt controller that funnels NSRC rising-edge
// sources onto one pulsed CPU interrupt line, holding off until software ACKs.
module irq_controller #(
  parameter int         NSRC      = 4,
  parameter logic [7:0] BASE      = 8'hF8,
  parameter int         PULSE_LEN = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic [7:0]      uaddr,
  input  logic [7:0]      udata_in,
  input  logic            rw,
  output logic [7:0]      rdata,
  output logic            rsel,
  output logic            interrupt
);

  localparam int CW = $clog2(PULSE_LEN + 1);

  typedef enum logic [1:0] {IDLE, ASSERT, WAIT_ACK} state_t;

  state_t          state;
  logic [NSRC-1:0] prev;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mask;
  logic            en;
  logic            vec_active;
  logic [2:0]      vec_idx;
  logic [CW-1:0]   cnt;

  logic            hit;
  logic            wr_pend;
  logic            wr_mask;
  logic            wr_ctrl;
  logic            en_next;
  logic            ack;
  logic [NSRC-1:0] edges;
  logic [NSRC-1:0] req;
  logic [NSRC-1:0] pend_clr;
  logic [2:0]      winner;
  logic            unused_ok;

  assign hit       = (uaddr[7:2] == BASE[7:2]);
  assign wr_pend   = rw && hit && (uaddr[1:0] == 2'd0);
  assign wr_mask   = rw && hit && (uaddr[1:0] == 2'd1);
  assign wr_ctrl   = rw && hit && (uaddr[1:0] == 2'd3);
  assign en_next   = wr_ctrl ? udata_in[0] : en;
  assign ack       = wr_ctrl && udata_in[1];
  assign edges     = irq_src & ~prev;
  assign req       = pend & mask;
  assign rsel      = hit && !rw;
  assign unused_ok = ^udata_in;

  // Software W1C plus the ACK of the vectored source; new edges override both.
  always_comb begin
    pend_clr = '0;
    if (wr_pend)
      pend_clr = udata_in[NSRC-1:0];
    if (state == WAIT_ACK && en_next && ack)
      pend_clr = pend_clr | (NSRC'(1) << vec_idx);
  end

  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (req[i])
        winner = 3'(i);
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (uaddr[1:0])
        2'd0:    rdata[NSRC-1:0] = pend;
        2'd1:    rdata[NSRC-1:0] = mask;
        2'd2:    rdata = {vec_active, 4'b0000, vec_idx};
        default: rdata = {7'b0000000, en};
      endcase
    end
  end

  // prev tracks the sources even in reset so a held-high line is not seen as an edge.
  always_ff @(posedge clk) begin
    prev <= irq_src;
    if (reset) begin
      state      <= IDLE;
      pend       <= '0;
      mask       <= '0;
      en         <= 1'b0;
      vec_active <= 1'b0;
      vec_idx    <= '0;
      cnt        <= '0;
      interrupt  <= 1'b0;
    end else begin
      pend <= (pend & ~pend_clr) | edges;
      if (wr_mask)
        mask <= udata_in[NSRC-1:0];
      if (wr_ctrl)
        en <= udata_in[0];

      case (state)
        IDLE: begin
          if (en && |req) begin
            state      <= ASSERT;
            vec_idx    <= winner;
            vec_active <= 1'b1;
            cnt        <= CW'(PULSE_LEN);
            interrupt  <= 1'b1;
          end
        end
        ASSERT: begin
          if (!en_next) begin
            state      <= IDLE;
            vec_active <= 1'b0;
            interrupt  <= 1'b0;
            cnt        <= '0;
          end else if (cnt <= CW'(1)) begin
            state     <= WAIT_ACK;
            interrupt <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_ACK: begin
          if (!en_next || ack) begin
            state      <= IDLE;
            vec_active <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed stimulus for irq_controller with a cycle-level
// behavioural model compared every cycle, plus hand-computed literal checks.
module tb_irq_controller;

  localparam int PULSE_LEN = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_src;
  logic [7:0] uaddr;
  logic [7:0] udata_in;
  logic       rw;
  logic [7:0] rdata;
  logic       rsel;
  logic       interrupt;

  int n_checks = 0;
  int n_fail   = 0;

  irq_controller #(
    .NSRC(4),
    .BASE(8'hF8),
    .PULSE_LEN(PULSE_LEN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .irq_src(irq_src),
    .uaddr(uaddr),
    .udata_in(udata_in),
    .rw(rw),
    .rdata(rdata),
    .rsel(rsel),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  // Behavioural model: pending set, mask, enable, and an in-flight dispatch
  // described by the number of interrupt cycles still to be shown.
  logic [3:0] m_prev, m_pend, m_mask;
  logic [2:0] m_vec;
  bit         m_en, m_active, model_ready;
  int         m_pulse;

  always @(posedge clk) begin : model
    logic [3:0] edges, clr, req;
    bit         new_en;
    int         wr_off;
    edges  = irq_src & ~m_prev;
    m_prev = irq_src;
    if (reset) begin
      m_pend = '0; m_mask = '0; m_vec = '0;
      m_en = 0; m_active = 0; m_pulse = 0;
      model_ready = 1;
    end else begin
      wr_off = (rw && ((uaddr & 8'hFC) == 8'hF8)) ? int'(uaddr & 8'h03) : -1;
      new_en = (wr_off == 3) ? udata_in[0] : m_en;
      clr    = (wr_off == 0) ? udata_in[3:0] : 4'b0000;
      if (m_active) begin
        if (!new_en) begin
          m_active = 0;
          m_pulse  = 0;
        end else if (m_pulse > 0) begin
          m_pulse--;
        end else if (wr_off == 3 && udata_in[1]) begin
          clr      = clr | 4'(1 << m_vec);
          m_active = 0;
        end
      end else begin
        req = m_pend & m_mask;
        if (m_en && req != 4'b0000) begin
          int k;
          k = 0;
          while (req[k] == 1'b0) k++;
          m_vec    = 3'(k);
          m_active = 1;
          m_pulse  = PULSE_LEN;
        end
      end
      m_pend = (m_pend & ~clr) | edges;
      if (wr_off == 1)
        m_mask = udata_in[3:0];
      m_en = new_en;
    end
  end

  function automatic logic [7:0] expRdata(input logic [7:0] a);
    if ((a & 8'hFC) != 8'hF8) return 8'h00;
    case (a & 8'h03)
      8'h00:   return {4'b0000, m_pend};
      8'h01:   return {4'b0000, m_mask};
      8'h02:   return {m_active, 4'b0000, m_vec};
      default: return {7'b0000000, m_en};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (model_ready) begin
      checkOutput("model_interrupt", {7'b0, interrupt}, {7'b0, (m_pulse > 0)});
      checkOutput("model_rdata", rdata, expRdata(uaddr));
      checkOutput("model_rsel", {7'b0, rsel},
                  {7'b0, ((uaddr & 8'hFC) == 8'hF8) && !rw});
    end
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d, input logic w, input logic [3:0] src);
    @(negedge clk);
    uaddr    = a;
    udata_in = d;
    rw       = w;
    irq_src  = src;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(8'h00, 8'h00, 1'b0, irq_src);
  endtask

  task automatic busWrite(input logic [7:0] a, input logic [7:0] d);
    applyStimulus(a, d, 1'b1, irq_src);
    applyStimulus(8'h00, 8'h00, 1'b0, irq_src);
  endtask

  task automatic readCheck(input logic [7:0] a, input logic [7:0] expected, input string name);
    @(negedge clk);
    uaddr    = a;
    udata_in = 8'h00;
    rw       = 1'b0;
    #1;
    checkOutput(name, rdata, expected);
    checkOutput({name, "_rsel"}, {7'b0, rsel}, {7'b0, ((a & 8'hFC) == 8'hF8)});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit exp_int [5] = '{0, 1, 1, 0, 0};
    reset = 1'b1; irq_src = 4'b0010; uaddr = 8'h00; udata_in = 8'h00; rw = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Source held high through reset must not register an edge.
    idle(2);
    readCheck(8'hF8, 8'h00, "reset_pend");
    checkOutput("reset_interrupt", {7'b0, interrupt}, 8'h00);
    readCheck(8'hFA, 8'h00, "reset_vector");
    readCheck(8'hFB, 8'h00, "reset_ctrl");

    // Single dispatch on source 2, then ACK.
    busWrite(8'hF9, 8'h0F);
    busWrite(8'hFB, 8'h01);
    applyStimulus(8'h00, 8'h00, 1'b0, 4'b0000);
    applyStimulus(8'h00, 8'h00, 1'b0, 4'b0100);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("pulse_cycle%0d", k + 1), {7'b0, interrupt}, {7'b0, exp_int[k]});
      if (k == 0) irq_src = 4'b0000;
    end
    readCheck(8'hFA, 8'h82, "vector_src2");
    busWrite(8'hFB, 8'h03);
    readCheck(8'hF8, 8'h00, "pend_after_ack");
    readCheck(8'hFA, 8'h02, "vector_after_ack");
    readCheck(8'hFB, 8'h01, "ctrl_ack_reads0");

    // Simultaneous edges on 3 and 1: lowest index first.
    applyStimulus(8'h00, 8'h00, 1'b0, 4'b1010);
    applyStimulus(8'h00, 8'h00, 1'b0, 4'b0000);
    readCheck(8'hFA, 8'h81, "vector_first_src1");
    idle(3);
    busWrite(8'hFB, 8'h03);
    readCheck(8'hFA, 8'h83, "vector_second_src3");
    checkOutput("second_dispatch_int", {7'b0, interrupt}, 8'h01);
    idle(3);
    busWrite(8'hFB, 8'h03);

    // Masked source stays pending until unmasked.
    busWrite(8'hF9, 8'h0E);
    applyStimulus(8'h00, 8'h00, 1'b0, 4'b0001);
    applyStimulus(8'h00, 8'h00, 1'b0, 4'b0000);
    idle(2);
    readCheck(8'hF8, 8'h01, "masked_pend");
    checkOutput("masked_no_int", {7'b0, interrupt}, 8'h00);
    busWrite(8'hF9, 8'h0F);
    readCheck(8'hFA, 8'h80, "vector_unmasked_src0");
    idle(3);
    busWrite(8'hFB, 8'h03);

    // W1C colliding with a new edge: the set wins.
    busWrite(8'hF9, 8'h00);
    applyStimulus(8'h00, 8'h00, 1'b0, 4'b0100);
    applyStimulus(8'h00, 8'h00, 1'b0, 4'b0000);
    applyStimulus(8'hF8, 8'h04, 1'b1, 4'b0100);
    applyStimulus(8'h00, 8'h00, 1'b0, 4'b0000);
    readCheck(8'hF8, 8'h04, "w1c_vs_set");
    busWrite(8'hF8, 8'h04);
    readCheck(8'hF8, 8'h00, "w1c_plain");
    busWrite(8'hF5, 8'hFF);
    readCheck(8'hF9, 8'h00, "outside_write_ignored");
    readCheck(8'hF7, 8'h00, "outside_read");

    // EN cleared mid-pulse aborts the dispatch but keeps PEND.
    busWrite(8'hF9, 8'h0F);
    applyStimulus(8'h00, 8'h00, 1'b0, 4'b0010);
    applyStimulus(8'h00, 8'h00, 1'b0, 4'b0000);
    applyStimulus(8'hFB, 8'h00, 1'b1, 4'b0000);
    #1;
    checkOutput("abort_int_before", {7'b0, interrupt}, 8'h01);
    readCheck(8'hFA, 8'h01, "abort_vector");
    checkOutput("abort_int_after", {7'b0, interrupt}, 8'h00);
    readCheck(8'hF8, 8'h02, "abort_pend_kept");
    readCheck(8'hFB, 8'h00, "abort_ctrl");

    // Reset while waiting for ACK.
    busWrite(8'hFB, 8'h01);
    idle(4);
    @(negedge clk);
    reset = 1'b1;
    readCheck(8'hF8, 8'h00, "midreset_pend");
    checkOutput("midreset_int", {7'b0, interrupt}, 8'h00);
    readCheck(8'hF9, 8'h00, "midreset_mask");
    readCheck(8'hFA, 8'h00, "midreset_vector");
    readCheck(8'hFB, 8'h00, "midreset_ctrl");
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    readCheck(8'hF8, 8'h00, "post_reset_pend");

    idle(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
